// File: rtl/fpga_fabric.sv
// rtl/fpga_fabric.sv - 14-cell five-input LUT fabric with routing pool and output crossbar
// Define CFG_PORT_EN to add a synchronous cfg_we/cfg_addr/cfg_data configuration write port.

module fpga_fabric_cell #(
  parameter int TT_W = 32,
  parameter int RT_W = 25
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_mem_we,
  input  logic            i_route_we,
  input  logic [TT_W:0]   i_cfg_data,
  input  logic            i_f,
  output logic [TT_W:0]   o_mem,
  output logic [RT_W-1:0] o_route,
  output logic            o_q
);

  logic [TT_W:0]   mem;
  logic [RT_W-1:0] route;
  logic            r_q;

  // Configuration is deliberately outside the reset domain.
  always_ff @(posedge i_clock) begin
    if (i_mem_we) begin
      mem <= i_cfg_data;
    end
    if (i_route_we) begin
      route <= i_cfg_data[RT_W-1:0];
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_q <= 1'b0;
    end else begin
      r_q <= i_f;
    end
  end

  assign o_mem   = mem;
  assign o_route = route;
  assign o_q     = r_q;

endmodule

module fpga_fabric #(
  parameter int NUM_LUT = 14,
  parameter int LUT_K   = 5,
  parameter int SEL_W   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c,
  input  logic       d,
  output logic [4:0] out
`ifdef CFG_PORT_EN
  ,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [32:0] cfg_data
`endif
);

  localparam int TT_W      = 2 ** LUT_K;
  localparam int RT_W      = LUT_K * SEL_W;
  localparam int POOL_W    = 2 ** SEL_W;
  localparam int NUM_OUT   = 5;
  localparam int OR_W      = NUM_OUT * SEL_W;
  localparam int CELL_BASE = 10;

  logic              w_cfg_we;
  logic [4:0]        w_cfg_addr;
  logic [TT_W:0]     w_cfg_data;

`ifdef CFG_PORT_EN
  assign w_cfg_we   = cfg_we;
  assign w_cfg_addr = cfg_addr;
  assign w_cfg_data = cfg_data;
`else
  assign w_cfg_we   = 1'b0;
  assign w_cfg_addr = '0;
  assign w_cfg_data = '0;
`endif

  logic [NUM_LUT-1:0] w_mem_we;
  logic [NUM_LUT-1:0] w_route_we;
  logic               w_oroute_we;
  logic [TT_W:0]      w_mem   [NUM_LUT];
  logic [RT_W-1:0]    w_route [NUM_LUT];
  logic [NUM_LUT-1:0] w_q;
  logic [NUM_LUT-1:0] w_f;
  logic [OR_W-1:0]    oroute;
  logic [POOL_W-1:0]  w_iter;
  logic [POOL_W-1:0]  w_next;
  logic [POOL_W-1:0]  w_pool;

  always_comb begin
    w_mem_we    = '0;
    w_route_we  = '0;
    w_oroute_we = w_cfg_we && (w_cfg_addr == 5'(2 * NUM_LUT));
    for (int j = 0; j < NUM_LUT; j++) begin
      w_mem_we[j]   = w_cfg_we && (w_cfg_addr == 5'(j));
      w_route_we[j] = w_cfg_we && (w_cfg_addr == 5'(NUM_LUT + j));
    end
  end

  always_ff @(posedge clock) begin
    if (w_oroute_we) begin
      oroute <= w_cfg_data[OR_W-1:0];
    end
  end

  function automatic logic lut_eval(input logic [TT_W-1:0]   tt,
                                    input logic [RT_W-1:0]   rt,
                                    input logic [POOL_W-1:0] pool);
    logic [LUT_K-1:0] idx;
    for (int n = 0; n < LUT_K; n++) begin
      idx[n] = pool[rt[n*SEL_W +: SEL_W]];
    end
    return tt[idx];
  endfunction

  // Legal configurations have a combinational depth of at most NUM_LUT cells, so
  // NUM_LUT relaxation passes settle every cell without a structural feedback path.
  always_comb begin
    w_iter       = '0;
    w_iter[3:0]  = A;
    w_iter[7:4]  = B;
    w_iter[8]    = c;
    w_iter[9]    = d;
    for (int j = 0; j < NUM_LUT; j++) begin
      w_iter[CELL_BASE+j] = w_mem[j][TT_W] & w_q[j];
    end
    w_next = w_iter;
    for (int s = 0; s < NUM_LUT; s++) begin
      w_next = w_iter;
      for (int j = 0; j < NUM_LUT; j++) begin
        w_next[CELL_BASE+j] = w_mem[j][TT_W] ? w_q[j]
                            : lut_eval(w_mem[j][TT_W-1:0], w_route[j], w_iter);
      end
      w_iter = w_next;
    end
    w_pool = w_iter;
    for (int j = 0; j < NUM_LUT; j++) begin
      w_f[j] = lut_eval(w_mem[j][TT_W-1:0], w_route[j], w_pool);
    end
    for (int k = 0; k < NUM_OUT; k++) begin
      out[k] = w_pool[oroute[k*SEL_W +: SEL_W]];
    end
  end

  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L1 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[0]), .i_route_we(w_route_we[0]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[0]), .o_mem(w_mem[0]), .o_route(w_route[0]), .o_q(w_q[0])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L2 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[1]), .i_route_we(w_route_we[1]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[1]), .o_mem(w_mem[1]), .o_route(w_route[1]), .o_q(w_q[1])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L3 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[2]), .i_route_we(w_route_we[2]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[2]), .o_mem(w_mem[2]), .o_route(w_route[2]), .o_q(w_q[2])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L4 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[3]), .i_route_we(w_route_we[3]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[3]), .o_mem(w_mem[3]), .o_route(w_route[3]), .o_q(w_q[3])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L5 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[4]), .i_route_we(w_route_we[4]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[4]), .o_mem(w_mem[4]), .o_route(w_route[4]), .o_q(w_q[4])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L6 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[5]), .i_route_we(w_route_we[5]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[5]), .o_mem(w_mem[5]), .o_route(w_route[5]), .o_q(w_q[5])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L7 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[6]), .i_route_we(w_route_we[6]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[6]), .o_mem(w_mem[6]), .o_route(w_route[6]), .o_q(w_q[6])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L8 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[7]), .i_route_we(w_route_we[7]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[7]), .o_mem(w_mem[7]), .o_route(w_route[7]), .o_q(w_q[7])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L9 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[8]), .i_route_we(w_route_we[8]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[8]), .o_mem(w_mem[8]), .o_route(w_route[8]), .o_q(w_q[8])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L10 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[9]), .i_route_we(w_route_we[9]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[9]), .o_mem(w_mem[9]), .o_route(w_route[9]), .o_q(w_q[9])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L11 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[10]), .i_route_we(w_route_we[10]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[10]), .o_mem(w_mem[10]), .o_route(w_route[10]), .o_q(w_q[10])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L12 (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[11]), .i_route_we(w_route_we[11]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[11]), .o_mem(w_mem[11]), .o_route(w_route[11]), .o_q(w_q[11])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L13_C (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[12]), .i_route_we(w_route_we[12]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[12]), .o_mem(w_mem[12]), .o_route(w_route[12]), .o_q(w_q[12])
  );
  fpga_fabric_cell #(.TT_W(TT_W), .RT_W(RT_W)) L14_D (
    .i_clock(clock), .i_reset(reset), .i_mem_we(w_mem_we[13]), .i_route_we(w_route_we[13]),
    .i_cfg_data(w_cfg_data), .i_f(w_f[13]), .o_mem(w_mem[13]), .o_route(w_route[13]), .o_q(w_q[13])
  );

endmodule

// File: tb/tb_fpga_fabric.sv
// tb/tb_fpga_fabric.sv - randomized self-checking bench for fpga_fabric against an arithmetic model
module tb_fpga_fabric;

  logic       clock;
  logic       reset;
  logic [3:0] A;
  logic [3:0] B;
  logic       c;
  logic       d;
  logic [4:0] out;
`ifdef CFG_PORT_EN
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [32:0] cfg_data = '0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fpga_fabric dut (
    .clock(clock),
    .reset(reset),
    .A(A),
    .B(B),
    .c(c),
    .d(d),
    .out(out)
`ifdef CFG_PORT_EN
    ,
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] rt(input int s0, input int s1, input int s2, input int s3, input int s4);
    return {5'(s4), 5'(s3), 5'(s2), 5'(s1), 5'(s0)};
  endfunction

  // kind 0: majority of i0..i2, kind 1: xor of i0..i2
  function automatic logic [31:0] tt3(input int kind);
    logic [31:0] t;
    int ones;
    for (int idx = 0; idx < 32; idx++) begin
      ones = (idx & 1) + ((idx >> 1) & 1) + ((idx >> 2) & 1);
      t[idx] = (kind == 0) ? (ones >= 2) : (ones % 2 == 1);
    end
    return t;
  endfunction

  task automatic set_cell(input int j, input logic [32:0] m, input logic [24:0] r);
    case (j)
      0:  begin dut.L1.mem    = m; dut.L1.route    = r; end
      1:  begin dut.L2.mem    = m; dut.L2.route    = r; end
      2:  begin dut.L3.mem    = m; dut.L3.route    = r; end
      3:  begin dut.L4.mem    = m; dut.L4.route    = r; end
      4:  begin dut.L5.mem    = m; dut.L5.route    = r; end
      5:  begin dut.L6.mem    = m; dut.L6.route    = r; end
      6:  begin dut.L7.mem    = m; dut.L7.route    = r; end
      7:  begin dut.L8.mem    = m; dut.L8.route    = r; end
      8:  begin dut.L9.mem    = m; dut.L9.route    = r; end
      9:  begin dut.L10.mem   = m; dut.L10.route   = r; end
      10: begin dut.L11.mem   = m; dut.L11.route   = r; end
      11: begin dut.L12.mem   = m; dut.L12.route   = r; end
      12: begin dut.L13_C.mem = m; dut.L13_C.route = r; end
      default: begin dut.L14_D.mem = m; dut.L14_D.route = r; end
    endcase
  endtask

  task automatic clear_config();
    for (int j = 0; j < 14; j++) set_cell(j, 33'h0, rt(24, 24, 24, 24, 24));
    dut.oroute = rt(24, 24, 24, 24, 24);
  endtask

  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic cc, input logic dd);
    @(negedge clock);
    A = a; B = b; c = cc; d = dd;
    #1;
  endtask

  logic [3:0]  fa [6] = '{4'b1010, 4'b1111, 4'b1011, 4'b1111, 4'b0000, 4'b0110};
  logic [3:0]  fb [6] = '{4'b0101, 4'b0101, 4'b1100, 4'b1111, 4'b0000, 4'b0110};
  logic        fc [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [4:0]  fo [6] = '{5'b10000, 5'b10100, 5'b10111, 5'b11111, 5'b00000, 5'b01101};

  initial begin
    logic [3:0]  ra, rb;
    logic        rc, rd, cap, v;
    logic [31:0] tt, pin;
    logic [4:0]  idx, exp_out;
    int          sel [5];
    int          r, k;

    reset = 1'b1; A = '0; B = '0; c = 1'b0; d = 1'b0;
    clear_config();
    set_cell(0, {1'b1, 32'hAAAAAAAA}, rt(0, 24, 24, 24, 24));
    dut.oroute = rt(10, 0, 24, 24, 24);
    apply(4'b0001, 4'b0, 1'b0, 1'b0);
    @(posedge clock); #1;
    check_eq("reset_reg_cell", 32'(out[0]), 32'd0);
    check_eq("reset_comb_route", 32'(out[1]), 32'd1);
    @(negedge clock); reset = 1'b0;

    clear_config();
    for (int i = 0; i < 4; i++) begin
      k = (i == 0) ? 8 : (10 + i - 1);
      set_cell(i, {1'b0, tt3(0)}, rt(i, 4 + i, k, 24, 24));
      set_cell(4 + i, {1'b0, tt3(1)}, rt(i, 4 + i, k, 24, 24));
    end
    dut.oroute = rt(14, 15, 16, 17, 13);
    for (int i = 0; i < 6; i++) begin
      apply(fa[i], fb[i], fc[i], 1'b0);
      check_eq($sformatf("adder_fixed%0d", i), 32'(out), 32'(fo[i]));
    end
    for (int i = 0; i < 30; i++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));  rd = 1'($urandom_range(0, 1));
      apply(ra, rb, rc, rd);
      check_eq($sformatf("adder_rand%0d", i), 32'(out), 32'(5'(ra) + 5'(rb) + 5'(rc)));
    end

    clear_config();
    for (int i = 0; i < 20; i++) begin
      tt = $urandom();
      for (int n = 0; n < 5; n++) begin
        r = $urandom_range(0, 17);
        sel[n] = (r < 10) ? r : r + 14;
      end
      set_cell(13, {1'b0, tt}, rt(sel[0], sel[1], sel[2], sel[3], sel[4]));
      dut.oroute = rt(23, 24, 24, 24, 24);
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));  rd = 1'($urandom_range(0, 1));
      apply(ra, rb, rc, rd);
      pin = {22'd0, rd, rc, rb, ra};
      for (int n = 0; n < 5; n++) idx[n] = pin[sel[n]];
      check_eq($sformatf("lut_rand%0d", i), 32'(out), {31'd0, tt[idx]});
    end

    clear_config();
    set_cell(0, {1'b0, 32'h55555555}, rt(0, 24, 24, 24, 24));
    for (int j = 1; j < 14; j++) set_cell(j, {1'b0, 32'h55555555}, rt(10 + j - 1, 24, 24, 24, 24));
    dut.oroute = rt(23, 22, 10, 24, 24);
    for (int i = 0; i < 6; i++) begin
      ra = 4'($urandom_range(0, 15));
      apply(ra, 4'd0, 1'b0, 1'b0);
      v = ra[0];
      exp_out = '0;
      for (int n = 1; n <= 14; n++) begin
        v = ~v;
        if (n == 1)  exp_out[2] = v;
        if (n == 13) exp_out[1] = v;
        if (n == 14) exp_out[0] = v;
      end
      check_eq($sformatf("chain%0d", i), 32'(out), 32'(exp_out));
    end

    clear_config();
    set_cell(0, {1'b1, 32'hAAAAAAAA}, rt(0, 24, 24, 24, 24));
    dut.oroute = rt(10, 1, 24, 24, 24);
    apply(4'b0010, 4'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    cap = 1'b0;
    apply(4'b0011, 4'd0, 1'b0, 1'b0);
    check_eq("reg_before_edge", 32'(out[0]), 32'(cap));
    @(posedge clock); #1;
    cap = 1'b1;
    check_eq("reg_after_edge", 32'(out[0]), 32'(cap));
    for (int i = 0; i < 16; i++) begin
      ra = 4'($urandom_range(0, 15));
      apply(ra, 4'd0, 1'b0, 1'b0);
      check_eq($sformatf("reg_hold%0d", i), 32'(out), {27'd0, 3'd0, ra[1], cap});
      @(posedge clock); #1;
      cap = ra[0];
      check_eq($sformatf("reg_cap%0d", i), 32'(out[0]), 32'(cap));
    end

    apply(4'b0011, 4'd0, 1'b0, 1'b0);
    @(posedge clock); #1;
    check_eq("areset_pre", 32'(out[0]), 32'd1);
    @(negedge clock); #2 reset = 1'b1; #1;
    check_eq("areset_immediate", 32'(out[0]), 32'd0);
    check_eq("areset_comb_follows", 32'(out[1]), 32'd1);
    @(posedge clock); #1;
    check_eq("areset_held", 32'(out[0]), 32'd0);
    @(negedge clock); reset = 1'b0; #1;
    check_eq("areset_released", 32'(out[0]), 32'd0);
    @(posedge clock); #1;
    check_eq("areset_recover", 32'(out[0]), 32'd1);

    for (int i = 0; i < 8; i++) begin
      dut.oroute = rt($urandom_range(24, 31), $urandom_range(24, 31), $urandom_range(24, 31),
                      $urandom_range(24, 31), $urandom_range(24, 31));
      apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b1);
      check_eq($sformatf("const_zero%0d", i), 32'(out), 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      for (int n = 0; n < 5; n++) sel[n] = (n == i) ? 9 : 24;
      dut.oroute = rt(sel[0], sel[1], sel[2], sel[3], sel[4]);
      apply(4'hF, 4'hF, 1'b1, 1'b1);
      check_eq($sformatf("sel_d_hi%0d", i), 32'(out), 32'(1) << i);
      apply(4'hF, 4'hF, 1'b1, 1'b0);
      check_eq($sformatf("sel_d_lo%0d", i), 32'(out), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpga_fabric.md
Name: fpga_fabric

Overview:
- Small configurable logic fabric: 14 five-input LUT cells, a global routing pool, and a configurable output crossbar.
- Cells are named L1..L12, L13_C and L14_D.
- Primary inputs are A[3:0], B[3:0], c and d; the primary output is out[4:0].
- Once configured, it implements small user circuits, e.g. a 4-bit adder with carry-in and carry-out.

Parameters:
- NUM_LUT, 14, number of LUT cells (fixed architecture value; not meant to be changed).
- LUT_K, 5, LUT input count; truth table is 2^LUT_K = 32 bits.
- SEL_W, 5, width of every routing selector.

Ports:
- clock  in  1  rising-edge clock for LUT output flops.
- reset  in  1  asynchronous, active-high; clears LUT output flops.
- A  in  4  user input bus A.
- B  in  4  user input bus B.
- c  in  1  user scalar input c (carry-in in adder mapping).
- d  in  1  user scalar input d.
- out  out  5  user output bus.

Behaviour:
- Routing pool, 5-bit index:
  - 0..3 = A[0..3]
  - 4..7 = B[0..3]
  - 8 = c
  - 9 = d
  - 10..23 = outputs of cells L1..L14 (L13_C = 22, L14_D = 23)
  - 24..31 = constant 0
- Per-cell configuration:
  - mem[32:0]: mem[31:0] is the truth table; mem[32] is the output-mode select.
  - route[24:0]: input i_n = pool[route[5n+4:5n]], for n = 0..4.
- LUT function: f = mem[{i4,i3,i2,i1,i0}].
- Cell output mode:
  - mem[32] = 0: combinational, cell output = f with zero latency.
  - mem[32] = 1: registered; a flop captures f on each clock rising edge, giving 1-cycle latency, and the cell output = flop.
- Output routing word oroute[24:0]: out[k] = pool[oroute[5k+4:5k]], for k = 0..4.
- reset:
  - Asserting reset immediately clears all 14 cell flops to 0, independent of clock.
  - Registered-mode cell outputs read 0 while reset is high.
  - Combinational cells and out still follow their inputs during reset.
- Configuration storage:
  - All mem, route and oroute registers are NOT affected by reset.
  - They power up X; benches may load them hierarchically (e.g. L1.mem, L1.route).
  - The configuration must be fully loaded before outputs are meaningful.
- A combinational loop through combinational-mode cells is an illegal configuration; behaviour is undefined. Loops must pass through at least one registered cell.
- Configuration changes take effect immediately: combinationally for routing and combinational cells, and at the next edge for flops.

Optional Feature:
- Macro CFG_PORT_EN.
- When defined, add these ports:
  - cfg_we in 1
  - cfg_addr in 5
  - cfg_data in 33
- Synchronous write on a clock rising edge when cfg_we = 1. Address map:
  - 0..13: mem of L1..L14 (all 33 bits).
  - 14..27: route of L1..L14 (cfg_data[24:0]).
  - 28: oroute (cfg_data[24:0]).
  - 29..31: ignored.
- reset does not block or clear configuration writes.
- When not defined: no extra ports; configuration is loadable only by hierarchical assignment.

Test Plan:
- Adder mapping, combinational cells:
  - L1..L4 compute carries c1..c4 (majority of A[i], B[i], carry-in).
  - L5..L8 compute sum bits (XOR3).
  - oroute maps out[3:0] = sums and out[4] = c4.
  - A=1010, B=0101, c=1 -> out=10000.
- Same mapping: A=1111, B=0101, c=0 -> out=10100; A=1011, B=1100, c=0 -> out=10111.
- Same mapping: A=1111, B=1111, c=1 -> out=11111; A=0000, B=0000, c=0 -> out=00000; A=0110, B=0110, c=1 -> out=01101.
- Registered mode:
  - L1 configured as buffer of A[0] (mem=0xAAAAAAAA with i0 = A[0], other inputs routed to 24) with mem[32]=1; out[0] routed to L1.
  - Toggle A[0] 0->1 -> out[0] rises only at the next clock rising edge.
- Async reset: L1 registered with out[0]=1, assert reset mid-cycle -> out[0]=0 immediately; after deassertion, out[0] returns to 1 at the first rising edge.
- Constant/route check: all out selectors = 24..31 -> out=00000; selector 9 with d=1 -> corresponding out bit = 1.
